// File: rtl/e203_tcm_loader_pkg.sv
// ---------------------------------------------------------------------------
// e203_tcm_loader_pkg
// Shared definitions for the TCM boot loader / SRAM port arbiter.
//   ldr_state_e : loader FSM state encoding
//   HDR_BYTES   : number of bytes in the little-endian length header
//   nb_of()     : bytes per TCM word for a given data width
// ---------------------------------------------------------------------------
package e203_tcm_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_WR,
        S_CKSUM,
        S_RUN,
        S_ERR
    } ldr_state_e;

    localparam int HDR_BYTES = 4;

    function automatic int nb_of(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/e203_tcm_byte_packer.sv
// ---------------------------------------------------------------------------
// e203_tcm_byte_packer
// Packs a little-endian byte stream into one TCM word, tracking which byte
// lanes have been filled.
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : store byte_in into the next free lane
//   byte_in    : incoming byte
//   clear      : restart a new word (lane index and mask cleared)
//   word       : packed word (unfilled lanes hold stale data)
//   mask       : one bit per filled lane
//   full       : the next push fills the last lane of the word
// ---------------------------------------------------------------------------
module e203_tcm_byte_packer
    import e203_tcm_loader_pkg::*;
#(
    parameter int DW = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [7:0]        byte_in,
    input  logic              clear,
    output logic [DW-1:0]     word,
    output logic [DW/8-1:0]   mask,
    output logic              full
);

    localparam int NB  = nb_of(DW);
    localparam int BIW = (NB > 1) ? $clog2(NB) : 1;

    logic [BIW-1:0] bi;

    assign full = (bi == BIW'(NB - 1));

    // Clear wins over push; the loader never does both in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word <= '0;
            mask <= '0;
            bi   <= '0;
        end else if (clear) begin
            mask <= '0;
            bi   <= '0;
        end else if (push) begin
            word[8*bi +: 8] <= byte_in;
            mask[bi]        <= 1'b1;
            bi              <= full ? '0 : bi + BIW'(1);
        end
    end

endmodule

// File: rtl/e203_tcm_boot_loader_arb.sv
// ---------------------------------------------------------------------------
// e203_tcm_boot_loader_arb
// Loads a TCM from a byte stream (4-byte LSB-first length header followed by
// the payload), holding the core in reset meanwhile, then hands the SRAM port
// to the core.
// Optional macro E203_TCM_LOADER_CKSUM_EN: a trailing XOR checksum byte is
// required after the payload (also when the length is zero).
//   clk, rst_n          : clock, asynchronous active-low reset
//   ld_bypass           : skip loading (sampled in IDLE)
//   ld_byte_vld/_rdy    : loader byte handshake, ld_byte data
//   core_cs/we/addr/wem/din : core SRAM request, serviced only in RUN
//   core_ready          : core owns the SRAM
//   ram_cs/we/addr/wem/din  : SRAM port
//   core_hold           : registered core reset hold
//   ld_done, ld_err     : sticky status flags
// ---------------------------------------------------------------------------
module e203_tcm_boot_loader_arb
    import e203_tcm_loader_pkg::*;
#(
    parameter int DW    = 64,
    parameter int AW    = 16,
    parameter int LEN_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_bypass,
    input  logic              ld_byte_vld,
    input  logic [7:0]        ld_byte,
    output logic              ld_byte_rdy,
    input  logic              core_cs,
    input  logic              core_we,
    input  logic [AW-1:0]     core_addr,
    input  logic [DW/8-1:0]   core_wem,
    input  logic [DW-1:0]     core_din,
    output logic              core_ready,
    output logic              ram_cs,
    output logic              ram_we,
    output logic [AW-1:0]     ram_addr,
    output logic [DW/8-1:0]   ram_wem,
    output logic [DW-1:0]     ram_din,
    output logic              core_hold,
    output logic              ld_done,
    output logic              ld_err
);

    localparam int NB = nb_of(DW);
    // Largest payload that fits the TCM; one extra bit avoids overflow.
    localparam logic [LEN_W:0] MAXB = (LEN_W + 1)'(NB) << AW;

    ldr_state_e state, state_nxt;

    logic [LEN_W-9:0] len_hi;
    logic [LEN_W-1:0] len_full;
    logic [LEN_W-1:0] rem;
    logic [1:0]       hdr_cnt;
    logic [AW-1:0]    waddr;
    logic             byte_acc;
    logic             hdr_last;
    logic [DW-1:0]    pk_word;
    logic [NB-1:0]    pk_mask;
    logic             pk_full;
`ifdef E203_TCM_LOADER_CKSUM_EN
    logic [7:0]       cksum;
`endif

    assign byte_acc = ld_byte_vld & ld_byte_rdy;
    assign hdr_last = (hdr_cnt == 2'(HDR_BYTES - 1));
    // Header shifts in from the top so byte 0 ends up in bits [7:0].
    assign len_full = {ld_byte, len_hi};
    assign core_ready = (state == S_RUN);

    e203_tcm_byte_packer #(.DW(DW)) u_packer (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (byte_acc && (state == S_DATA)),
        .byte_in (ld_byte),
        .clear   (state == S_WR),
        .word    (pk_word),
        .mask    (pk_mask),
        .full    (pk_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        ld_byte_rdy = 1'b0;
        ram_cs      = 1'b0;
        ram_we      = 1'b0;
        ram_addr    = '0;
        ram_wem     = '0;
        ram_din     = '0;
        case (state)
            S_IDLE: state_nxt = ld_bypass ? S_RUN : S_LEN;
            S_LEN: begin
                ld_byte_rdy = 1'b1;
                if (byte_acc && hdr_last) begin
                    if (len_full == '0) begin
`ifdef E203_TCM_LOADER_CKSUM_EN
                        state_nxt = S_CKSUM;
`else
                        state_nxt = S_RUN;
`endif
                    end else if ({1'b0, len_full} > MAXB) begin
                        state_nxt = S_ERR;
                    end else begin
                        state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                ld_byte_rdy = 1'b1;
                if (byte_acc && (pk_full || rem == LEN_W'(1))) state_nxt = S_WR;
            end
            S_WR: begin
                ram_cs   = 1'b1;
                ram_we   = 1'b1;
                ram_addr = waddr;
                ram_wem  = pk_mask;
                ram_din  = pk_word;
                if (rem != '0) state_nxt = S_DATA;
`ifdef E203_TCM_LOADER_CKSUM_EN
                else           state_nxt = S_CKSUM;
`else
                else           state_nxt = S_RUN;
`endif
            end
`ifdef E203_TCM_LOADER_CKSUM_EN
            S_CKSUM: begin
                ld_byte_rdy = 1'b1;
                if (byte_acc) state_nxt = (ld_byte == cksum) ? S_RUN : S_ERR;
            end
`endif
            S_RUN: begin
                ram_cs   = core_cs;
                ram_we   = core_we;
                ram_addr = core_addr;
                ram_wem  = core_wem;
                ram_din  = core_din;
            end
            S_ERR: ld_byte_rdy = 1'b1;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_hi    <= '0;
            rem       <= '0;
            hdr_cnt   <= '0;
            waddr     <= '0;
            core_hold <= 1'b1;
            ld_done   <= 1'b0;
            ld_err    <= 1'b0;
`ifdef E203_TCM_LOADER_CKSUM_EN
            cksum     <= '0;
`endif
        end else begin
            case (state)
                S_LEN: begin
                    if (byte_acc) begin
                        len_hi  <= len_full[LEN_W-1:8];
                        hdr_cnt <= hdr_cnt + 2'd1;
                        if (hdr_last) begin
                            rem   <= len_full;
                            waddr <= '0;
                        end
                    end
                end
                S_DATA: begin
                    if (byte_acc) begin
                        rem   <= rem - LEN_W'(1);
`ifdef E203_TCM_LOADER_CKSUM_EN
                        cksum <= cksum ^ ld_byte;
`endif
                    end
                end
                S_WR:  waddr <= waddr + AW'(1);
                S_RUN: begin
                    ld_done   <= 1'b1;
                    core_hold <= 1'b0;
                end
                S_ERR: ld_err <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule
